// File: rtl/sorted_ram_loader_if.sv
// Handshake and RAM-port bundle between the sorted RAM loader and its environment.
interface sorted_ram_loader_if #(
  parameter int N  = 8,
  parameter int AW = 5
);
  logic          clear;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          busy;
  logic [AW:0]   count;
  logic          full;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_wren;
  logic [N-1:0]  mem_rdata;

  modport slave (
    input  clear, in_valid, in_data, mem_rdata,
    output in_ready, busy, count, full, mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output clear, in_valid, in_data, mem_rdata,
    input  in_ready, busy, count, full, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/sorted_ram_loader.sv
// Insertion-sort loader: keeps a single-port RAM ascending and padded with all-ones,
// one RAM access per cycle.
//
// state | meaning
// INIT  | write all-ones pad to every address, init_ptr walks 0..DEPTH-1
// IDLE  | accept a value or a clear request
// RD    | present address ptr-1 to the RAM
// CMP   | entry[ptr-1] on mem_rdata; shift it up if larger than val
// PLACE | write val at ptr, bump count
module sorted_ram_loader #(
  parameter int N  = 8,
  parameter int AW = 5
) (
  input logic                clk,
  input logic                rst,
  sorted_ram_loader_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {INIT, IDLE, RD, CMP, PLACE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] init_ptr, init_ptr_nxt;
  logic [AW:0]   ptr, ptr_nxt;
  logic [AW:0]   count, count_nxt;
  logic [N-1:0]  val, val_nxt;

  assign bus.count = count;
  assign bus.full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
      ptr      <= '0;
      count    <= '0;
      val      <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
      ptr      <= ptr_nxt;
      count    <= count_nxt;
      val      <= val_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_ptr_nxt  = init_ptr;
    ptr_nxt       = ptr;
    count_nxt     = count;
    val_nxt       = val;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_wdata = '1;
    bus.mem_wren  = 1'b0;

    unique case (state)
      INIT: begin
        bus.mem_addr = init_ptr;
        bus.mem_wren = 1'b1;
        count_nxt    = '0;
        if (init_ptr == AW'(DEPTH - 1)) begin
          state_nxt    = IDLE;
          init_ptr_nxt = '0;
        end else begin
          init_ptr_nxt = init_ptr + AW'(1);
        end
      end

      IDLE: begin
        bus.busy     = 1'b0;
        bus.in_ready = !bus.full && !bus.clear;
        // clear wins over in_valid, so no value is lost into a re-padded array
        if (bus.clear) begin
          state_nxt    = INIT;
          count_nxt    = '0;
          init_ptr_nxt = '0;
        end else if (bus.in_valid && bus.in_ready) begin
          val_nxt   = bus.in_data;
          ptr_nxt   = count;
          state_nxt = (count == '0) ? PLACE : RD;
        end
      end

      RD: begin
        bus.mem_addr = ptr[AW-1:0] - AW'(1);
        state_nxt    = CMP;
      end

      CMP: begin
        // strict compare keeps equal values in arrival order
        if (bus.mem_rdata > val) begin
          bus.mem_addr  = ptr[AW-1:0];
          bus.mem_wdata = bus.mem_rdata;
          bus.mem_wren  = 1'b1;
          ptr_nxt       = ptr - (AW+1)'(1);
          state_nxt     = (ptr == (AW+1)'(1)) ? PLACE : RD;
        end else begin
          state_nxt = PLACE;
        end
      end

      PLACE: begin
        bus.mem_addr  = ptr[AW-1:0];
        bus.mem_wdata = val;
        bus.mem_wren  = 1'b1;
        count_nxt     = count + (AW+1)'(1);
        state_nxt     = IDLE;
      end

      default: state_nxt = INIT;
    endcase
  end
endmodule

// File: tb/tb_sorted_ram_loader.sv
// Bench for sorted_ram_loader: RAM model, write scoreboard, latency and content checks.
module tb_sorted_ram_loader;
  localparam int N  = 8;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sorted_ram_loader_if #(.N(N), .AW(AW)) bus ();

  sorted_ram_loader #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port RAM: registered address, unregistered q
  logic [N-1:0]  ram [DEPTH];
  logic [AW-1:0] addr_q;
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    addr_q <= bus.mem_addr;
  end
  assign bus.mem_rdata = ram[addr_q];

  logic [AW+N-1:0] exp_wr[$];
  logic [N-1:0]    model[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // every RAM write the DUT commits is popped against the scoreboard
  always @(negedge clk) begin
    logic [AW+N-1:0] e;
    if (!rst && bus.mem_wren) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected_addr", 32'(exp_wr.size()), 32'(bus.mem_addr) + 1000);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e[AW+N-1:N]));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e[N-1:0]));
      end
    end
  end

  task automatic push_pads();
    for (int i = 0; i < DEPTH; i++) exp_wr.push_back({AW'(i), {N{1'b1}}});
  endtask

  task automatic wait_idle(output int cyc);
    bit done;
    cyc  = 0;
    done = 1'b0;
    for (int g = 0; g < 2000 && !done; g++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
      else cyc++;
    end
    if (!done) chk("idle_timeout", 32'(cyc), 32'(0));
  endtask

  task automatic ram_check(input string tag);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_ram%0d", tag, i), 32'(ram[i]),
          32'((i < model.size()) ? model[i] : {N{1'b1}}));
  endtask

  // builds the expected shift/place writes before the handshake edge
  task automatic predict(input logic [N-1:0] v, output int exp_cyc);
    int c, j, k;
    c = model.size();
    j = c - 1;
    k = 0;
    while (j >= 0 && model[j] > v) begin
      exp_wr.push_back({AW'(j + 1), model[j]});
      j--;
      k++;
    end
    exp_wr.push_back({AW'(j + 1), v});
    model.insert(j + 1, v);
    exp_cyc = (k == c) ? 2 * k + 1 : 2 * k + 3;
  endtask

  task automatic handshake(input logic [N-1:0] v, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("handshake_timeout", 32'(bus.in_ready), 32'(1));
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic insert(input logic [N-1:0] v);
    bit ok;
    int cyc, exp_cyc;
    handshake(v, ok);
    if (ok) begin
      predict(v, exp_cyc);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_idle(cyc);
      chk($sformatf("ins_cycles_%0d", v), 32'(cyc), 32'(exp_cyc));
    end
  endtask

  task automatic do_clear();
    int cyc;
    @(posedge clk); #1;
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h07;
    @(negedge clk);
    chk("ready_during_clear", 32'(bus.in_ready), 32'(0));
    push_pads();
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    wait_idle(cyc);
    chk("clear_init_cycles", 32'(cyc), 32'(DEPTH));
    model.delete();
    chk("count_after_clear", 32'(bus.count), 32'(0));
    chk("wr_queue_after_clear", 32'(exp_wr.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, exp_cyc;
    bit  ok;
    n_vec = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(bus.busy),      32'(1));
    chk("rst_ready",    32'(bus.in_ready),  32'(0));
    chk("rst_wren",     32'(bus.mem_wren),  32'(1));
    chk("rst_addr",     32'(bus.mem_addr),  32'(0));
    chk("rst_wdata",    32'(bus.mem_wdata), 32'(8'hFF));
    chk("rst_count",    32'(bus.count),     32'(0));
    chk("rst_full",     32'(bus.full),      32'(0));

    @(posedge clk); #1;
    rst = 1'b0;
    push_pads();
    wait_idle(cyc);
    chk("init_cycles", 32'(cyc), 32'(DEPTH));
    chk("idle_ready",  32'(bus.in_ready), 32'(1));
    chk("idle_count",  32'(bus.count),    32'(0));
    chk("init_wr_left", 32'(exp_wr.size()), 32'(0));
    ram_check("init");

    insert(8'd40);
    insert(8'd10);
    insert(8'd30);
    insert(8'd20);
    chk("count_4", 32'(bus.count), 32'(4));
    ram_check("four");

    insert(8'd50);
    chk("count_5", 32'(bus.count), 32'(5));
    do_clear();
    ram_check("cleared");

    insert(8'd25);
    insert(8'd25);
    chk("count_dup", 32'(bus.count), 32'(2));
    ram_check("dup");

    do_clear();
    for (int v = DEPTH - 1; v >= 0; v--) insert(N'(v));
    chk("full_flag",  32'(bus.full),  32'(1));
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    repeat (5) begin
      @(negedge clk);
      chk("full_holdoff_ready", 32'(bus.in_ready), 32'(0));
      chk("full_holdoff_busy",  32'(bus.busy),     32'(0));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ram_check("full");

    do_clear();
    for (int v = 1; v <= 10; v++) insert(N'(v * 10));
    chk("count_10", 32'(bus.count), 32'(10));
    handshake(8'd5, ok);
    if (ok) begin
      predict(8'd5, exp_cyc);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_wr.delete();
      chk("async_rst_wren",  32'(bus.mem_wren),  32'(1));
      chk("async_rst_addr",  32'(bus.mem_addr),  32'(0));
      chk("async_rst_wdata", 32'(bus.mem_wdata), 32'(8'hFF));
      chk("async_rst_busy",  32'(bus.busy),      32'(1));
      chk("async_rst_ready", 32'(bus.in_ready),  32'(0));
      chk("async_rst_count", 32'(bus.count),     32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push_pads();
      wait_idle(cyc);
      chk("rst_reinit_cycles", 32'(cyc), 32'(DEPTH));
      chk("rst_reinit_count",  32'(bus.count), 32'(0));
      model.delete();
      ram_check("reinit");
      insert(8'd99);
      ram_check("after_reinit");
    end

    repeat (3) @(negedge clk);
    chk("final_wr_left", 32'(exp_wr.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
